// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK).
// Ports:
//   clk, reset      - clock, asynchronous active-low reset
//   PortIn          - external input, read as zero-extended word at IO_ADDR+4
//   mem_*           - single request/ack memory port, shared by fetch and data
//   ALUResultOut    - ALU result registered in the last EXECUTE
//   PortOut         - output register written by sw to IO_ADDR
//   illegal_op      - one-cycle pulse while an unsupported instruction decodes
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC     = 32'h0040_0000,
  parameter logic [31:0] IO_ADDR      = 32'h1001_0040,
  parameter int          PORTIN_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PORTIN_WIDTH-1:0] PortIn,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic [31:0]             mem_rdata,
  input  logic                    mem_ack,
  output logic [31:0]             ALUResultOut,
  output logic [31:0]             PortOut,
  output logic                    illegal_op
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK} state_t;

  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D,
                         OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                         F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_NOR = 6'h27,
                         F_SLT = 6'h2A;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d, port_out_q, port_out_d;
  logic [31:0] rf [32];
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, alu_res;
  logic        legal;

  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt;
  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign shamt = ir_q[10:6];
  assign funct = ir_q[5:0];

  logic is_lw, is_sw, io_hit;
  assign is_lw = (op == OP_LW);
  assign is_sw = (op == OP_SW);
  // Data accesses that hit the I/O window never reach the memory port.
  assign io_hit = (is_sw && alu_q == IO_ADDR) || (is_lw && alu_q == IO_ADDR + 32'd4);

  // Request gated by reset so an outstanding transaction drops immediately.
  assign mem_req      = reset && (state_q == FETCH || (state_q == MEMORY && !io_hit));
  assign mem_we       = reset && state_q == MEMORY && is_sw && !io_hit;
  assign mem_addr     = (state_q == MEMORY) ? alu_q : pc_q;
  assign mem_wdata    = b_q;
  assign ALUResultOut = alu_q;
  assign PortOut      = port_out_q;
  assign illegal_op   = (state_q == DECODE) && !legal;

  always_comb begin
    legal = 1'b0;
    case (op)
      OP_R: legal = funct inside {F_SLL, F_SRL, F_JR, F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT};
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = '0;
    if (op == OP_R) begin
      case (funct)
        F_ADD:   alu_res = a_q + b_q;
        F_SUB:   alu_res = a_q - b_q;
        F_AND:   alu_res = a_q & b_q;
        F_OR:    alu_res = a_q | b_q;
        F_NOR:   alu_res = ~(a_q | b_q);
        F_SLT:   alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
        F_SLL:   alu_res = b_q << shamt;
        F_SRL:   alu_res = b_q >> shamt;
        F_JR:    alu_res = a_q;
        default: alu_res = '0;
      endcase
    end else begin
      case (op)
        OP_ADDI, OP_LW, OP_SW: alu_res = a_q + imm_q;
        OP_ANDI:               alu_res = a_q & {16'd0, ir_q[15:0]};
        OP_ORI:                alu_res = a_q | {16'd0, ir_q[15:0]};
        OP_LUI:                alu_res = {ir_q[15:0], 16'd0};
        OP_BEQ, OP_BNE:        alu_res = a_q - b_q;
        default:               alu_res = '0;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    imm_d      = imm_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    port_out_d = port_out_q;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    case (state_q)
      FETCH: if (mem_ack) begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + 32'd4;
        state_d = DECODE;
      end
      DECODE: begin
        a_d   = rf[rs];
        b_d   = rf[rt];
        imm_d = {{16{ir_q[15]}}, ir_q[15:0]};
        if (!legal) state_d = FETCH;
        else if (op == OP_J || op == OP_JAL) begin
          // pc_q already holds PC+4, which is also the jal link value.
          pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
          state_d = FETCH;
          if (op == OP_JAL) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = pc_q;
          end
        end else state_d = EXECUTE;
      end
      EXECUTE: begin
        alu_d   = alu_res;
        state_d = WRITEBACK;
        if (op == OP_BEQ || op == OP_BNE) begin
          state_d = FETCH;
          if ((a_q == b_q) == (op == OP_BEQ)) pc_d = pc_q + (imm_q << 2);
        end else if (op == OP_R && funct == F_JR) begin
          pc_d    = a_q;
          state_d = FETCH;
        end else if (is_lw || is_sw) state_d = MEMORY;
      end
      MEMORY: begin
        if (io_hit) begin
          if (is_sw) begin
            port_out_d = b_q;
            state_d    = FETCH;
          end else begin
            mdr_d   = 32'(PortIn);
            state_d = WRITEBACK;
          end
        end else if (mem_ack) begin
          if (is_sw) state_d = FETCH;
          else begin
            mdr_d   = mem_rdata;
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        rf_we    = 1'b1;
        rf_waddr = (op == OP_R) ? rd : rt;
        rf_wdata = is_lw ? mdr_q : alu_q;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      alu_q      <= '0;
      mdr_q      <= '0;
      port_out_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      imm_q      <= imm_d;
      alu_q      <= alu_d;
      mdr_q      <= mdr_d;
      port_out_q <= port_out_d;
    end
  end

  // $0 is never written, so it always reads as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_we && rf_waddr != 5'd0) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
module tb_mips_multicycle_core;
  logic        clk = 0, rst_n = 0;
  logic [7:0]  port_in = 0;
  logic        mem_req, mem_we, mem_ack = 0, illegal_op;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, alu_out, port_out;

  mips_multicycle_core dut (
    .clk(clk), .reset(rst_n), .PortIn(port_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ALUResultOut(alu_out), .PortOut(port_out), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  txn_t        exp_q[$];
  int          hs_cyc[$], hs_len[$];
  logic [31:0] mem [int unsigned];
  int          n_chk = 0, n_fail = 0, cyc = 0, ill_cnt = 0, data_delay = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a >> 2)) return mem[a >> 2];
    return 32'd0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder plus scoreboard monitor.
  int          wcnt = 0, t_len = 0;
  logic        in_txn = 0, t_we;
  logic [31:0] t_addr, t_wd;
  always @(negedge clk) begin
    if (illegal_op) ill_cnt++;
    if (!mem_req) begin
      mem_ack = 0; wcnt = 0; in_txn = 0;
    end else begin
      int dly;
      if (!in_txn) begin
        in_txn = 1; t_addr = mem_addr; t_we = mem_we; t_wd = mem_wdata; t_len = 0;
      end else begin
        check("hold_addr", mem_addr, t_addr);
        check("hold_we", {31'd0, mem_we}, {31'd0, t_we});
        if (t_we) check("hold_wdata", mem_wdata, t_wd);
      end
      t_len++;
      dly = (!mem_we && mem_addr < 32'h0040_0000) ? data_delay : 0;
      if (wcnt >= dly) begin
        mem_ack = 1;
        mem_rdata = rd_mem(mem_addr);
        if (mem_we) mem[mem_addr >> 2] = mem_wdata;
        hs_cyc.push_back(cyc);
        hs_len.push_back(t_len);
        if (exp_q.size() > 0) begin
          txn_t e;
          e = exp_q.pop_front();
          check("txn_addr", mem_addr, e.addr);
          check("txn_we", {31'd0, mem_we}, {31'd0, e.we});
          if (e.we) check("txn_wdata", mem_wdata, e.wdata);
        end
        in_txn = 0; wcnt = 0;
      end else begin
        mem_ack = 0; wcnt++;
      end
    end
  end

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] tgt);
    return {op, tgt[27:2]};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w); mem[a >> 2] = w; endtask
  task automatic ef(input logic [31:0] a); exp_q.push_back('{1'b0, a, 32'd0}); endtask
  task automatic ew(input logic [31:0] a, input logic [31:0] d); exp_q.push_back('{1'b1, a, d}); endtask

  task automatic start_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    exp_q.delete(); hs_cyc.delete(); hs_len.delete(); mem.delete();
    ill_cnt = 0; data_delay = 0;
  endtask
  task automatic release_reset();
    @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin @(posedge clk); n++; end
    check(nm, exp_q.size(), 0);
    #1;
  endtask
  function automatic int dcyc(input int i, input int j);
    if (hs_cyc.size() <= j) return -1;
    return hs_cyc[j] - hs_cyc[i];
  endfunction

  initial begin
    // Reset state.
    start_reset();
    check("rst_mem_req", {31'd0, mem_req}, 0);
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_portout", port_out, 0);
    check("rst_alu", alu_out, 0);
    check("rst_illegal", {31'd0, illegal_op}, 0);

    // addi/addi/add then store of $t2.
    put(32'h0040_0000, enc_i(6'h08, 0, 8, 16'd5));
    put(32'h0040_0004, enc_i(6'h08, 0, 9, 16'hFFFD));
    put(32'h0040_0008, enc_r(8, 9, 10, 0, 6'h20));
    put(32'h0040_000C, enc_i(6'h2B, 0, 10, 16'h0100));
    put(32'h0040_0010, enc_r(8, 9, 11, 0, 6'h20));
    put(32'h0040_0014, enc_j(6'h02, 32'h0040_0014));
    ef(32'h0040_0000); ef(32'h0040_0004); ef(32'h0040_0008); ef(32'h0040_000C);
    ew(32'h0000_0100, 32'd2); ef(32'h0040_0010); ef(32'h0040_0014); ef(32'h0040_0014);
    release_reset();
    wait_drain("t1_drain");
    check("t1_alu", alu_out, 32'd2);
    check("t1_cycles3", dcyc(0, 3), 12);
    check("t1_sw_cyc", dcyc(3, 5), 4);
    check("t1_j_cyc", dcyc(6, 7), 2);

    // ALU coverage: slt, sub, nor, sll, srl, andi.
    start_reset();
    put(32'h0040_0000, enc_i(6'h08, 0, 8, 16'hFFFD));
    put(32'h0040_0004, enc_i(6'h08, 0, 9, 16'd5));
    put(32'h0040_0008, enc_r(8, 9, 10, 0, 6'h2A));
    put(32'h0040_000C, enc_r(9, 8, 11, 0, 6'h22));
    put(32'h0040_0010, enc_r(8, 0, 12, 0, 6'h27));
    put(32'h0040_0014, enc_r(0, 9, 13, 4, 6'h00));
    put(32'h0040_0018, enc_r(0, 8, 14, 28, 6'h02));
    put(32'h0040_001C, enc_i(6'h0C, 8, 15, 16'hFF00));
    for (int i = 0; i < 6; i++) put(32'h0040_0020 + 4 * i, enc_i(6'h2B, 0, 5'(10 + i), 16'(16'h0110 + 4 * i)));
    put(32'h0040_0038, enc_j(6'h02, 32'h0040_0038));
    for (int i = 0; i < 8; i++) ef(32'h0040_0000 + 4 * i);
    ef(32'h0040_0020); ew(32'h110, 32'd1);
    ef(32'h0040_0024); ew(32'h114, 32'd8);
    ef(32'h0040_0028); ew(32'h118, 32'd2);
    ef(32'h0040_002C); ew(32'h11C, 32'h50);
    ef(32'h0040_0030); ew(32'h120, 32'hF);
    ef(32'h0040_0034); ew(32'h124, 32'h0000_FF00);
    ef(32'h0040_0038); ef(32'h0040_0038);
    release_reset();
    wait_drain("alu_drain");

    // beq taken at 0x00400010 with imm -4.
    start_reset();
    put(32'h0040_0000, enc_j(6'h02, 32'h0040_0010));
    put(32'h0040_0004, enc_j(6'h02, 32'h0040_0004));
    put(32'h0040_0010, enc_i(6'h04, 0, 0, 16'hFFFC));
    ef(32'h0040_0000); ef(32'h0040_0010); ef(32'h0040_0004); ef(32'h0040_0004);
    release_reset();
    wait_drain("beq_drain");
    check("beq_cyc", dcyc(1, 2), 3);

    // bne with equal operands falls through.
    start_reset();
    put(32'h0040_0000, enc_j(6'h02, 32'h0040_0010));
    put(32'h0040_0010, enc_i(6'h05, 0, 0, 16'hFFFC));
    put(32'h0040_0014, enc_j(6'h02, 32'h0040_0014));
    ef(32'h0040_0000); ef(32'h0040_0010); ef(32'h0040_0014); ef(32'h0040_0014);
    release_reset();
    wait_drain("bne_drain");
    check("bne_cyc", dcyc(1, 2), 3);

    // jal / jr $ra round trip, then store $31.
    start_reset();
    put(32'h0040_0000, enc_j(6'h02, 32'h0040_0020));
    put(32'h0040_0020, enc_j(6'h03, 32'h0040_0100));
    put(32'h0040_0100, enc_r(31, 0, 0, 0, 6'h08));
    put(32'h0040_0024, enc_i(6'h2B, 0, 31, 16'h0104));
    put(32'h0040_0028, enc_j(6'h02, 32'h0040_0028));
    ef(32'h0040_0000); ef(32'h0040_0020); ef(32'h0040_0100); ef(32'h0040_0024);
    ew(32'h104, 32'h0040_0024); ef(32'h0040_0028); ef(32'h0040_0028);
    release_reset();
    wait_drain("jal_drain");
    check("jal_cyc", dcyc(1, 2), 2);
    check("jr_cyc", dcyc(2, 3), 3);

    // Memory-mapped I/O.
    start_reset();
    port_in = 8'h3C;
    put(32'h0040_0000, enc_i(6'h0F, 0, 1, 16'h1001));
    put(32'h0040_0004, enc_i(6'h0D, 0, 2, 16'h00A5));
    put(32'h0040_0008, enc_i(6'h2B, 1, 2, 16'h0040));
    put(32'h0040_000C, enc_i(6'h23, 1, 3, 16'h0044));
    put(32'h0040_0010, enc_i(6'h2B, 0, 3, 16'h0108));
    put(32'h0040_0014, enc_j(6'h02, 32'h0040_0014));
    for (int i = 0; i < 5; i++) ef(32'h0040_0000 + 4 * i);
    ew(32'h108, 32'h3C); ef(32'h0040_0014); ef(32'h0040_0014);
    release_reset();
    wait_drain("io_drain");
    check("io_portout", port_out, 32'hA5);
    check("io_sw_cyc", dcyc(2, 3), 4);
    check("io_lw_cyc", dcyc(3, 4), 5);
    start_reset();
    check("rst_portout2", port_out, 0);

    // lw with ack delayed by 3 cycles.
    put(32'h0000_0200, 32'hDEAD_BEEF);
    put(32'h0040_0000, enc_i(6'h23, 0, 4, 16'h0200));
    put(32'h0040_0004, enc_i(6'h2B, 0, 4, 16'h010C));
    put(32'h0040_0008, enc_j(6'h02, 32'h0040_0008));
    ef(32'h0040_0000); ef(32'h200); ef(32'h0040_0004); ew(32'h10C, 32'hDEAD_BEEF);
    ef(32'h0040_0008); ef(32'h0040_0008);
    data_delay = 3;
    release_reset();
    wait_drain("lwdly_drain");
    check("lwdly_len", (hs_len.size() > 1) ? hs_len[1] : -1, 4);
    check("lwdly_cyc", dcyc(0, 2), 8);

    // Reset asserted while a load is waiting for its ack.
    start_reset();
    put(32'h0040_0000, enc_i(6'h23, 0, 4, 16'h0200));
    data_delay = 10;
    ef(32'h0040_0000);
    release_reset();
    begin
      int n = 0;
      bit seen = 0;
      while (!seen && n < 50) begin
        @(negedge clk);
        n++;
        if (mem_req && mem_addr == 32'h200) seen = 1;
      end
      check("abort_reached_mem", {31'd0, seen}, 1);
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("abort_req", {31'd0, mem_req}, 0);
    check("abort_alu", alu_out, 0);
    ef(32'h0040_0000);
    release_reset();
    wait_drain("abort_refetch");

    // Unsupported opcode 0x3F.
    start_reset();
    put(32'h0040_0000, 32'hFC00_0000);
    put(32'h0040_0004, enc_j(6'h02, 32'h0040_0004));
    ef(32'h0040_0000); ef(32'h0040_0004); ef(32'h0040_0004);
    release_reset();
    wait_drain("ill_drain");
    check("ill_pulse", ill_cnt, 1);
    check("ill_cyc", dcyc(0, 1), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
